uart_image_loader: RTL and testbench
====================================

// Module: uart_image_loader
// PURPOSE
//   UART receive front-end for the SNN input stage.
//   - Deserialises 8N1 bytes (8 data bits, no parity, 1 stop bit) from uart_rx.
//   - Writes each received byte into the SNN input-pixel RAM at a sequential address.
//   - Raises image_done once a full image (NUM_PIXELS bytes) is stored, then holds
//     until the SNN core acknowledges. Sits between the board RX pin and the input RAM.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        115_200      UART bit rate
//   NUM_PIXELS  784          bytes per image (28x28)
//   ADDR_W      10           RAM address width; NUM_PIXELS <= 2**ADDR_W
//   CLKS_PER_BIT is a localparam = CLK_FREQ/BAUD (integer divide); must be >= 4
// PORTS
//   clk          in   1       system clock; all logic on posedge
//   sys_rst_n    in   1       asynchronous active-low reset
//   uart_rx      in   1       serial line, idle high; asynchronous to clk
//   wr_en        out  1       one-cycle write strobe to input RAM
//   wr_addr      out  ADDR_W  pixel address for the write
//   wr_data      out  8       received pixel byte
//   image_done   out  1       level: image complete, waiting for image_ack
//   image_ack    in   1       SNN consumed image; re-arms loader
//   frame_err    out  1       one-cycle pulse: stop bit sampled low
//   overrun      out  1       one-cycle pulse: byte arrived while image_done=1
// BEHAVIOUR
//   Reset values: all outputs 0; RX FSM = IDLE; pixel counter = 0; synchroniser flops = 1.
//   Input synchroniser: uart_rx passes through 2 flops; FSMs use only the synced value.
//   RX FSM (bit counter 0..7, baud counter 0..CLKS_PER_BIT-1):
//     IDLE:  synced line low -> START, baud counter cleared.
//     START: at count CLKS_PER_BIT/2 resample.
//            - low  -> DATA (mid-bit alignment established).
//            - high -> IDLE (glitch rejected, no output).
//     DATA:  sample every CLKS_PER_BIT; LSB first; after bit 7 -> STOP.
//     STOP:  sample at the next bit centre.
//            - high -> byte valid.
//            - low  -> frame_err pulse, byte discarded; go to BREAK.
//            - either case, line high -> IDLE.
//     BREAK: wait for synced line high -> IDLE (no restart on a held-low line).
//   Loader FSM:
//     LOAD: each valid byte -> wr_en=1 for exactly one cycle, the cycle after the
//           stop-bit sample, with wr_addr=count and wr_data=byte; count increments.
//           - Write at addr NUM_PIXELS-1 -> count=0, image_done=1 the cycle after
//             that write, go FULL.
//     FULL: image_done held high.
//           - Valid byte -> overrun pulse, no write, count unchanged.
//           - image_ack=1 -> image_done=0 next cycle, go LOAD.
//   image_ack is ignored in LOAD.
//   Same-cycle valid byte and image_ack in FULL: ack wins; the byte is dropped and
//     pulses overrun.
//   wr_addr is held at its last value when wr_en=0.
//   Back-to-back bytes (stop bit directly followed by a start bit) are accepted
//     with no lost bytes.
//   Reset asserted mid-byte or mid-image: the partial byte and image are discarded
//     and the next image starts at addr 0.
//   Latency: stop-bit centre sample -> wr_en is 1 clk; line start edge -> sampling
//     adds 2 clk of synchroniser delay.
// CONFIGURATION
//   UART_PARITY_EN defined:
//     - RX FSM inserts a PARITY state after DATA that samples an even-parity bit.
//     - Parity mismatch -> byte discarded and frame_err pulsed (same as a bad stop bit).
//     - Frame becomes 8E1.
//   UART_PARITY_EN undefined: 8N1, no PARITY state, no parity logic synthesised.
// STRUCTURE
//   Package snn_uart_pkg:
//     - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}
//     - typedef enum load_state_t {LOAD, FULL}
//     - localparam NUM_PIXELS_DEFAULT = 784
//   Sub-module uart_rx_core: synchroniser + RX FSM. Outputs rx_byte[7:0], rx_valid
//     (1 clk) and rx_frame_err (1 clk). Loader FSM and counter stay in this top module.
// TESTING (bench: CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit, NUM_PIXELS=4)
//   1. Send 0xA5 with sys_rst_n high -> exactly one wr_en, wr_addr=0, wr_data=0xA5;
//      no frame_err.
//   2. Send 0x01,0x02,0x03,0x04 back-to-back -> writes to addr 0..3; image_done rises
//      1 clk after the addr-3 write.
//   3. Hold image_done, send 0x55 -> one overrun pulse, no wr_en; pulse image_ack ->
//      image_done falls; send 0x77 -> write at addr 0.
//   4. Send 0x3C with stop bit forced low -> frame_err pulse, no wr_en; hold line low
//      30 clk, then idle and send 0x11 -> written at next addr.
//   5. Low glitch of 3 clk on idle line -> no write, no frame_err.
//   6. Assert sys_rst_n low after 2 of 4 bytes, release, send 4 bytes -> writes at
//      addr 0..3, then image_done. With UART_PARITY_EN, a bad parity bit on 0x0F ->
//      frame_err, no write.

Source files
------------

// File: rtl/snn_uart_pkg.sv
// Shared types and defaults for the SNN UART image loader.
package snn_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  typedef enum logic {LOAD, FULL} load_state_t;

  localparam int unsigned NUM_PIXELS_DEFAULT = 784;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchroniser plus RX FSM (8N1, or 8E1 when
// UART_PARITY_EN is defined). rx_valid / rx_frame_err are single-cycle strobes.
module uart_rx_core
  import snn_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2);
  localparam logic [BAUD_W-1:0] LAST_CNT = BAUD_W'(CLKS_PER_BIT - 1);

  logic [1:0]        sync_q, sync_d;
  rx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_s;
  logic              parity_ok;

  assign rx_s    = sync_q[1];
  assign rx_byte = shift_q;

`ifdef UART_PARITY_EN
  logic parity_ok_q, parity_ok_d;
  assign parity_ok = parity_ok_q;
`else
  assign parity_ok = 1'b1;
`endif

  // Strobes are decoded from the stop-bit sample cycle so the loader's
  // registered write lands exactly one clock after that sample.
  always_comb begin
    sync_d       = {sync_q[0], rx};
    state_d      = state_q;
    baud_d       = baud_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
`ifdef UART_PARITY_EN
    parity_ok_d  = parity_ok_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (baud_q == HALF_BIT) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == LAST_CNT) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_q == LAST_CNT) begin
          baud_d      = '0;
          parity_ok_d = (rx_s == ^shift_q);
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_q == LAST_CNT) begin
          baud_d = '0;
          if (rx_s && parity_ok) rx_valid = 1'b1;
          else                   rx_frame_err = 1'b1;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
`ifdef UART_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
`ifdef UART_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

endmodule

// File: rtl/uart_image_loader.sv
// UART image loader: writes received bytes to the SNN input RAM sequentially and
// flags image_done after NUM_PIXELS bytes. Define UART_PARITY_EN for 8E1 frames.
module uart_image_loader
  import snn_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              uart_rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              image_done,
  input  logic              image_ack,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_core (
    .clk          (clk),
    .rst_n        (sys_rst_n),
    .rx           (uart_rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              image_done_q, image_done_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    image_done_d = image_done_q;
    frame_err_d  = rx_frame_err;
    overrun_d    = 1'b0;
    case (state_q)
      LOAD: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = rx_byte;
          if (count_q == LAST_ADDR) begin
            count_d = '0;
            state_d = FULL;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FULL: begin
        // image_done follows FULL by one cycle, i.e. one clock after the last write.
        image_done_d = 1'b1;
        if (rx_valid) overrun_d = 1'b1;
        if (image_ack) begin
          image_done_d = 1'b0;
          state_d      = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= LOAD;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      image_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      image_done_q <= image_done_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign image_done = image_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader: 10 clk/bit, 4-pixel images.
module tb_uart_image_loader;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned BAUD       = 100_000;
  localparam int unsigned NUM_PIXELS = 4;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned BIT_CLKS   = 10;

  logic              clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              image_ack = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              image_done;
  logic              frame_err;
  logic              overrun;

  uart_image_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rx    (uart_rx),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .image_done (image_done),
    .image_ack  (image_ack),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int unsigned cyc = 0, wr_n = 0, fe_cnt = 0, ov_cnt = 0;
  int unsigned last_wr_cyc = 0, done_rise_cyc = 0;
  logic        done_prev = 1'b0;
  logic [ADDR_W-1:0] log_addr [64];
  logic [7:0]        log_data [64];

  always @(negedge clk) begin
    cyc++;
    if (wr_en === 1'b1) begin
      if (wr_n < 64) begin
        log_addr[wr_n] = wr_addr;
        log_data[wr_n] = wr_data;
      end
      wr_n++;
      last_wr_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (image_done === 1'b1 && !done_prev) done_rise_cyc = cyc;
    done_prev = (image_done === 1'b1);
  end

  int unsigned rd = 0;
  int unsigned fe_base = 0;
  int unsigned ov_base = 0;

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                           input logic bad_par = 1'b0);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
    drive_bit((^b) ^ bad_par);
`else
    if (bad_par) drive_bit(1'b1);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int unsigned n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    if (rd < wr_n) begin
      check({tag, "_addr"}, 32'(log_addr[rd]), 32'(a));
      check({tag, "_data"}, 32'(log_data[rd]), 32'(d));
      rd++;
    end else begin
      check({tag, "_missing_wr"}, wr_n, rd + 1);
    end
  endtask

  task automatic reset_dut();
    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    image_ack = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_image_done", 32'(image_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    sys_rst_n = 1'b1;
    idle(5);

    // 1: single byte
    send_byte(8'hA5);
    idle(20);
    expect_wr("t1", 0, 8'hA5);
    check("t1_wr_count", wr_n, rd);
    check("t1_frame_err", fe_cnt, 0);

    // 2: full image back-to-back
    reset_dut();
    for (int unsigned i = 1; i <= 4; i++) send_byte(8'(i));
    idle(20);
    for (int unsigned i = 0; i < 4; i++) expect_wr("t2", ADDR_W'(i), 8'(i + 1));
    check("t2_wr_count", wr_n, rd);
    check("t2_image_done", 32'(image_done), 1);
    check("t2_done_latency", done_rise_cyc - last_wr_cyc, 1);

    // 3: overrun while full, then ack and reload
    ov_base = ov_cnt;
    send_byte(8'h55);
    idle(20);
    check("t3_overrun", ov_cnt - ov_base, 1);
    check("t3_no_wr", wr_n, rd);
    check("t3_done_held", 32'(image_done), 1);
    image_ack = 1'b1;
    @(negedge clk);
    image_ack = 1'b0;
    check("t3_done_fall", 32'(image_done), 0);
    send_byte(8'h77);
    idle(20);
    expect_wr("t3", 0, 8'h77);
    check("t3_wr_count", wr_n, rd);

    // 4: bad stop bit, held-low line, recovery
    fe_base = fe_cnt;
    send_byte(8'h3C, 1'b0);
    uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    idle(20);
    check("t4_frame_err", fe_cnt - fe_base, 1);
    check("t4_no_wr", wr_n, rd);
    send_byte(8'h11);
    idle(20);
    expect_wr("t4", 1, 8'h11);
    check("t4_wr_count", wr_n, rd);

    // 5: short low glitch on idle line
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("t5_no_wr", wr_n, rd);
    check("t5_no_frame_err", fe_cnt - fe_base, 1);

    // 6: reset mid-image and mid-byte
    reset_dut();
    send_byte(8'h21);
    send_byte(8'h22);
    idle(20);
    expect_wr("t6a", 0, 8'h21);
    expect_wr("t6a", 1, 8'h22);
    uart_rx = 1'b0;
    repeat (25) @(negedge clk);
    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    idle(20);
    check("t6_partial_no_wr", wr_n, rd);
    for (int unsigned i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
    idle(20);
    for (int unsigned i = 0; i < 4; i++) expect_wr("t6b", ADDR_W'(i), 8'(8'h31 + i));
    check("t6_wr_count", wr_n, rd);
    check("t6_image_done", 32'(image_done), 1);
    check("t6_done_latency", done_rise_cyc - last_wr_cyc, 1);

`ifdef UART_PARITY_EN
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    send_byte(8'h0F, 1'b1, 1'b1);
    idle(20);
    check("par_frame_err", fe_cnt - fe_base, 1);
    check("par_no_overrun", ov_cnt - ov_base, 0);
    check("par_no_wr", wr_n, rd);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
